// File: rtl/rd_tag_alloc_pkg.sv
// rtl/rd_tag_alloc_pkg.sv - shared tID sizing and tagged request layout for the read path
package rd_tag_alloc_pkg;

  localparam int MAX_TID    = 16;
  localparam int TID_WIDTH  = $clog2(MAX_TID);
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;

  // tid sits in the MSBs so downstream hit/miss FIFO consumers find it at fixed bits
  typedef struct packed {
    logic [TID_WIDTH-1:0]  tid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
  } tagged_req_t;

endpackage

// File: rtl/rd_tag_alloc_tid_id_table.sv
// rtl/rd_tag_alloc_tid_id_table.sv - tID to AXI ID register file, sync write, async read
module rd_tag_alloc_tid_id_table #(
  parameter int DEPTH     = 16,
  parameter int IDX_WIDTH = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_WIDTH-1:0] i_waddr,
  input  logic [ID_WIDTH-1:0]  i_wdata,
  input  logic [IDX_WIDTH-1:0] i_raddr,
  output logic [ID_WIDTH-1:0]  o_rdata
);

  logic [ID_WIDTH-1:0] r_mem [DEPTH];

  // storage is written only on accept; contents are meaningless until a tID is allocated
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rd_tag_alloc.sv
// rtl/rd_tag_alloc.sv - stamps AXI read-address beats with sequential tIDs and tracks credit
module rd_tag_alloc #(
  parameter int ID_WIDTH   = rd_tag_alloc_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH = rd_tag_alloc_pkg::ADDR_WIDTH,
  parameter int MAX_TID    = rd_tag_alloc_pkg::MAX_TID,
  parameter int TID_WIDTH  = $clog2(MAX_TID)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [TID_WIDTH-1:0]  req_tid_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  ret_valid_i,
  input  logic [TID_WIDTH-1:0]  ret_tid_i,
  output logic [ID_WIDTH-1:0]   ret_rid_o,
  output logic [TID_WIDTH:0]    inflight_o,
  output logic                  err_o
);

  localparam logic [TID_WIDTH-1:0] LAST_TID = TID_WIDTH'(MAX_TID - 1);
  localparam logic [TID_WIDTH:0]   FULL_CNT = (TID_WIDTH + 1)'(MAX_TID);

  logic [TID_WIDTH-1:0]  r_alloc_ptr;
  logic [TID_WIDTH-1:0]  r_ret_ptr;
  logic [TID_WIDTH:0]    r_inflight;
  logic                  r_req_valid;
  logic [TID_WIDTH-1:0]  r_req_tid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_err;

  logic w_can_load;
  logic w_has_credit;
  logic w_accept;
  logic w_ret_legal;
  logic w_ret_bad;

  // arready depends only on registered state and downstream ready, never on arvalid
  assign w_can_load   = !r_req_valid || req_ready_i;
  assign w_has_credit = r_inflight < FULL_CNT;
  assign arready_o    = !rst && w_can_load && w_has_credit;
  assign w_accept     = arvalid_i && arready_o;
  assign w_ret_legal  = ret_valid_i && (r_inflight != '0) && (ret_tid_i == r_ret_ptr);
  assign w_ret_bad    = ret_valid_i && !w_ret_legal;

  // one-deep output slot: load on accept, drop once consumed, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_req_tid   <= '0;
      r_req_addr  <= '0;
    end else if (w_accept) begin
      r_req_valid <= 1'b1;
      r_req_tid   <= r_alloc_ptr;
      r_req_addr  <= araddr_i;
    end else if (req_ready_i) begin
      r_req_valid <= 1'b0;
    end
  end

  // allocation and retire pointers wrap at MAX_TID-1, which need not be a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_alloc_ptr <= (r_alloc_ptr == LAST_TID) ? '0 : r_alloc_ptr + TID_WIDTH'(1);
      end
      if (w_ret_legal) begin
        r_ret_ptr <= (r_ret_ptr == LAST_TID) ? '0 : r_ret_ptr + TID_WIDTH'(1);
      end
    end
  end

  // outstanding count: accept adds, legal retire subtracts, both together cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_ret_legal})
        2'b10:   r_inflight <= r_inflight + (TID_WIDTH + 1)'(1);
        2'b01:   r_inflight <= r_inflight - (TID_WIDTH + 1)'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // any out-of-order or underflowing retire latches the error until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_ret_bad) begin
      r_err <= 1'b1;
    end
  end

  rd_tag_alloc_tid_id_table #(
    .DEPTH     (MAX_TID),
    .IDX_WIDTH (TID_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_table (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_alloc_ptr),
    .i_wdata (arid_i),
    .i_raddr (ret_tid_i),
    .o_rdata (ret_rid_o)
  );

  assign req_valid_o = r_req_valid;
  assign req_tid_o   = r_req_tid;
  assign req_addr_o  = r_req_addr;
  assign inflight_o  = r_inflight;
  assign err_o       = r_err;

endmodule
